// File: rtl/cceip_kernel_pkg.sv
// Shared definitions for the CCEIP output packer.
// Contents: packer states, beat geometry and the byte-lane mask helper.
package cceip_kernel_pkg;

    localparam int BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_DROP,
        S_PAD,
        S_DONE
    } state_e;

    // Expands a contiguous tkeep into a 64-bit mask so that invalid byte lanes read as zero.
    function automatic logic [63:0] laneMask(input logic [BEAT_BYTES-1:0] keep);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cceip_output_packer_if.sv
// AXI-Stream bundle shared by the packer's input and output sides.
// tkeep and tlast are carried on both sides; the write-master side uses them as status only.
interface cceip_output_packer_if #(
    parameter int DATA_W = 64
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/cceip_output_packer.sv
// Packs the CCEIP output stream into exactly ceil(capacity/8) beats for the AXI write master.
// Surplus payload is swallowed and flagged; short payload is padded out with zero beats.
module cceip_output_packer
    import cceip_kernel_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_SIZE_WIDTH = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    start,
    input  logic [C_SIZE_WIDTH-1:0] capacity_bytes,
    cceip_output_packer_if.slave    s,
    cceip_output_packer_if.master   m,
    output logic [C_SIZE_WIDTH-1:0] byte_count,
    output logic                    overflow,
    output logic                    done
);

    localparam int KEEP_W = C_DATA_WIDTH / 8;
    localparam int BEAT_W = C_SIZE_WIDTH - 2;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       capBeats_q, capBeats_d;
    logic [BEAT_W-1:0]       beatCnt_q, beatCnt_d;
    logic [BEAT_W-1:0]       beatNext;
    logic [C_SIZE_WIDTH-1:0] byteCount_q, byteCount_d;
    logic                    overflow_q, overflow_d;
    logic                    passOpen;
    logic                    lastOut;

    function automatic logic [3:0] popcount(input logic [KEEP_W-1:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    assign beatNext   = beatCnt_q + BEAT_W'(1);
    assign passOpen   = beatCnt_q < capBeats_q;
    assign lastOut    = beatNext == capBeats_q;
    assign byte_count = byteCount_q;
    assign overflow   = overflow_q;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            capBeats_q  <= '0;
            beatCnt_q   <= '0;
            byteCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            capBeats_q  <= capBeats_d;
            beatCnt_q   <= beatCnt_d;
            byteCount_q <= byteCount_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        capBeats_d  = capBeats_q;
        beatCnt_d   = beatCnt_q;
        byteCount_d = byteCount_q;
        overflow_d  = overflow_q;
        s.tready    = 1'b0;
        m.tvalid    = 1'b0;
        m.tdata     = '0;
        m.tkeep     = '0;
        m.tlast     = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Rounding is done one bit wider so a capacity near the top of the range cannot wrap.
                    capBeats_d  = BEAT_W'(({1'b0, capacity_bytes} + (C_SIZE_WIDTH+1)'(BEAT_BYTES-1)) >> 3);
                    beatCnt_d   = '0;
                    byteCount_d = '0;
                    overflow_d  = 1'b0;
                    state_d     = S_PASS;
                end
            end

            S_PASS: begin
                if (!passOpen) begin
                    state_d = S_DROP;
                end else begin
                    m.tvalid = s.tvalid;
                    s.tready = m.tready;
                    m.tdata  = s.tdata & laneMask(s.tkeep);
                    m.tkeep  = '1;
                    m.tlast  = lastOut;
                    if (s.tvalid && m.tready) begin
                        beatCnt_d   = beatNext;
                        byteCount_d = byteCount_q + C_SIZE_WIDTH'(popcount(s.tkeep));
                        if (s.tlast) begin
                            state_d = lastOut ? S_DONE : S_PAD;
                        end else if (lastOut) begin
                            state_d = S_DROP;
                        end
                    end
                end
            end

            S_DROP: begin
                s.tready = 1'b1;
                if (s.tvalid) begin
                    overflow_d = 1'b1;
                    if (s.tlast) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_PAD: begin
                m.tvalid = 1'b1;
                m.tkeep  = '1;
                m.tlast  = lastOut;
                if (m.tready) begin
                    beatCnt_d = beatNext;
                    if (lastOut) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cceip_output_packer.sv
// Randomized bench for cceip_output_packer against a job-level model of beats, bytes and overflow.
// Directed jobs pin the model with hand-computed results before the random sweep.
module tb_cceip_output_packer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] capacity_bytes = '0;
    logic [63:0] byte_count;
    logic        overflow;
    logic        done;

    cceip_output_packer_if #(.DATA_W(64)) sIf ();
    cceip_output_packer_if #(.DATA_W(64)) mIf ();

    cceip_output_packer #(
        .C_DATA_WIDTH(64),
        .C_SIZE_WIDTH(64)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .start          (start),
        .capacity_bytes (capacity_bytes),
        .s              (sIf),
        .m              (mIf),
        .byte_count     (byte_count),
        .overflow       (overflow),
        .done           (done)
    );

    initial forever #5 ap_clk = ~ap_clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] expQ[$];
    logic [63:0] expBeat;
    logic [63:0] expByteCount = '0;
    logic        expOverflow = 1'b0;
    int          expBeatTotal = 0;
    int          mBeatsJob = 0;
    int          doneCnt = 0;
    bit          jobActive = 1'b0;
    bit          prevDone = 1'b0;
    logic [63:0] doneByteCount = '0;
    logic        doneOverflow = 1'b0;
    logic [7:0]  jobKeep[$];
    bit          readyPat[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Downstream ready: scripted pattern when one is queued, otherwise random back-pressure.
    initial begin
        mIf.tready = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            if (readyPat.size() > 0) mIf.tready = readyPat.pop_front();
            else mIf.tready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (mIf.tvalid && mIf.tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("m_extra_beat", 64'(mIf.tdata), 64'hdead_beef_dead_beef);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("m_tdata", mIf.tdata, expBeat);
                    checkOutput("m_tlast", 64'(mIf.tlast), 64'(expQ.size() == 0));
                end
                mBeatsJob++;
            end
            if (done) begin
                checkOutput("done_byte_count", byte_count, expByteCount);
                checkOutput("done_overflow", 64'(overflow), 64'(expOverflow));
                checkOutput("done_beats_out", 64'(mBeatsJob), 64'(expBeatTotal));
                checkOutput("done_single_cycle", 64'(prevDone), 64'(0));
                doneByteCount = byte_count;
                doneOverflow  = overflow;
                doneCnt++;
                jobActive = 1'b0;
            end else if (!jobActive) begin
                checkOutput("idle_s_tready", 64'(sIf.tready), 64'(0));
                checkOutput("idle_m_tvalid", 64'(mIf.tvalid), 64'(0));
            end
            prevDone = done;
        end else begin
            prevDone = 1'b0;
        end
    end

    // Builds the expected beat list for the job in jobKeep, then starts it and feeds numBeats beats.
    task automatic startJob(input longint cap, input int numBeats, output logic [63:0] data[$]);
        int n;
        int capB;
        n = jobKeep.size();
        capB = int'((cap + 7) / 8);
        expByteCount = '0;
        expQ.delete();
        data.delete();
        for (int b = 0; b < n; b++) begin
            logic [63:0] d;
            logic [63:0] md;
            d = {$urandom, $urandom};
            data.push_back(d);
            if (b < capB) begin
                md = '0;
                for (int l = 0; l < 8; l++) begin
                    if (jobKeep[b][l]) begin
                        md[l*8 +: 8] = d[l*8 +: 8];
                        expByteCount = expByteCount + 64'd1;
                    end
                end
                expQ.push_back(md);
            end
        end
        for (int b = n; b < capB; b++) expQ.push_back(64'd0);
        expBeatTotal = capB;
        expOverflow  = (n > capB);
        mBeatsJob    = 0;

        @(posedge ap_clk);
        #1;
        jobActive      = 1'b1;
        start          = 1'b1;
        capacity_bytes = 64'(cap);
        @(posedge ap_clk);
        #1;
        start          = 1'b0;
        capacity_bytes = {$urandom, $urandom};
        driveBeats(data, numBeats);
    endtask

    task automatic driveBeats(input logic [63:0] data[$], input int numBeats);
        int i;
        int budget;
        bit hs;
        i = 0;
        budget = 0;
        sIf.tvalid = 1'b0;
        while (i < numBeats && budget < 2000) begin
            if (!sIf.tvalid && $urandom_range(0, 3) != 0) begin
                sIf.tvalid = 1'b1;
                sIf.tdata  = data[i];
                sIf.tkeep  = jobKeep[i];
                sIf.tlast  = (i == jobKeep.size() - 1);
            end
            @(negedge ap_clk);
            hs = sIf.tvalid && sIf.tready;
            @(posedge ap_clk);
            #1;
            if (hs) begin
                i++;
                sIf.tvalid = 1'b0;
            end
            budget++;
        end
        sIf.tvalid = 1'b0;
        if (i < numBeats) checkOutput("s_accept_timeout", 64'(i), 64'(numBeats));
    endtask

    task automatic applyStimulus(input longint cap, input int litBytes, input int litBeats, input int litOvf);
        logic [63:0] data[$];
        int startDone;
        int budget;
        startDone = doneCnt;
        startJob(cap, jobKeep.size(), data);
        budget = 0;
        while (doneCnt == startDone && budget < 500) begin
            @(posedge ap_clk);
            budget++;
        end
        #1;
        if (doneCnt == startDone) begin
            checkOutput("done_timeout", 64'(doneCnt), 64'(startDone + 1));
        end else begin
            if (litBytes >= 0) checkOutput("lit_byte_count", doneByteCount, 64'(litBytes));
            if (litBeats >= 0) checkOutput("lit_beats_out", 64'(mBeatsJob), 64'(litBeats));
            if (litOvf >= 0)   checkOutput("lit_overflow", 64'(doneOverflow), 64'(litOvf));
        end
    endtask

    task automatic resetMidJob();
        logic [63:0] data[$];
        int startDone;
        jobKeep = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        startJob(32, 1, data);
        startDone = doneCnt;
        ap_rst_n  = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b1;
        jobActive = 1'b0;
        expQ.delete();
        @(negedge ap_clk);
        checkOutput("rst_mid_s_tready", 64'(sIf.tready), 64'(0));
        checkOutput("rst_mid_m_tvalid", 64'(mIf.tvalid), 64'(0));
        checkOutput("rst_mid_m_tdata", mIf.tdata, 64'(0));
        checkOutput("rst_mid_byte_count", byte_count, 64'(0));
        checkOutput("rst_mid_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_mid_done", 64'(done), 64'(0));
        repeat (5) @(posedge ap_clk);
        checkOutput("rst_mid_no_done", 64'(doneCnt), 64'(startDone));
        jobKeep = '{8'hFF};
        applyStimulus(8, 8, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sIf.tvalid = 1'b0;
        sIf.tdata  = '0;
        sIf.tkeep  = '0;
        sIf.tlast  = 1'b0;
        ap_rst_n   = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_byte_count", byte_count, 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_s_tready", 64'(sIf.tready), 64'(0));
        checkOutput("rst_m_tvalid", 64'(mIf.tvalid), 64'(0));
        checkOutput("rst_m_tdata", mIf.tdata, 64'(0));
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        jobKeep = '{8'hFF, 8'hFF, 8'h0F};
        applyStimulus(32, 20, 4, 0);
        jobKeep = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        applyStimulus(16, 16, 2, 1);
        jobKeep = '{8'hFF, 8'hFF, 8'hFF};
        applyStimulus(17, 24, 3, 0);
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        jobKeep = '{8'hFF};
        applyStimulus(16, 8, 2, 0);
        jobKeep = '{8'hFF};
        applyStimulus(0, 0, 0, 1);
        jobKeep = '{8'h00, 8'h03};
        applyStimulus(24, 2, 3, 0);
        resetMidJob();

        for (int j = 0; j < 40; j++) begin
            int n;
            int k;
            jobKeep.delete();
            n = $urandom_range(1, 14);
            for (int b = 0; b < n; b++) begin
                k = $urandom_range(0, 8);
                jobKeep.push_back(8'((9'h1 << k) - 9'h1));
            end
            applyStimulus(longint'($urandom_range(0, 100)), -1, -1, -1);
        end

        repeat (4) @(posedge ap_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
